// File: rtl/mc_mips_core.sv
// mc_mips_core: multi-cycle MIPS subset core with private instruction and data
// memories that are filled through a load port while the core is held idle.
//
// Ports:
//   clk                      single clock, all state updates on the rising edge
//   rst                      synchronous active-high reset (memories keep contents)
//   enable                   load mode: write both memories, force IDLE, pc = 0
//   inst_write_address/data  instruction-memory load port
//   mem_write_input_address/data  data-memory load port
//   start                    pulse to leave IDLE/HALT and begin fetching
//   dbg_addr / dbg_data      combinational register-file read
//   busy                     high in FETCH, DECODE, EXEC, MEM, WB
//   halted                   high in HALT
//   pc                       current word-address program counter
//   retired                  completed (non-halt) instruction count
//
// state  | meaning
// IDLE   | waiting for start, memories loadable
// FETCH  | ir <= imem[pc]
// DECODE | latch rs/rt values and sign-extended immediate
// EXEC   | ALU result latched; beq/j/no-op finish here, halt opcode goes to HALT
// MEM    | sw writes dmem and finishes; lw reads dmem
// WB     | register write for R-type/addi/lw, instruction finishes
// HALT   | stopped with pc on the halt instruction

module mc_mips_core #(
   parameter int         ADDR_W   = 10,
   parameter logic [5:0] HALT_OPC = 6'h3F
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [ADDR_W-1:0] inst_write_address,
   input  logic [31:0]       inst_write_data,
   input  logic [ADDR_W-1:0] mem_write_input_address,
   input  logic [31:0]       mem_write_input_data,
   input  logic              start,
   input  logic [4:0]        dbg_addr,
   output logic [31:0]       dbg_data,
   output logic              busy,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       retired
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0] imem [DEPTH];
   logic [31:0] dmem [DEPTH];
   logic [31:0] rf   [32];

   logic [2:0]        state;
   logic [ADDR_W-1:0] pc_q;
   logic [31:0]       retired_q;
   logic [31:0]       ir, a_reg, b_reg, imm_reg, res_reg, mdr;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic        rtype_ok;
   logic [31:0] alu_out;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
   logic        rf_we;
   logic [ADDR_W-1:0] pc_seq, pc_branch, data_addr;

   assign opcode = ir[31:26];
   assign rs     = ir[25:21];
   assign rt     = ir[20:16];
   assign rd     = ir[15:11];
   assign funct  = ir[5:0];

   assign rtype_ok = (opcode == OP_RTYPE) &&
                     (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                      funct == 6'h25 || funct == 6'h2A);

   always_comb begin
      alu_out = a_reg + imm_reg;
      if (opcode == OP_RTYPE) begin
         case (funct)
            6'h20:   alu_out = a_reg + b_reg;
            6'h22:   alu_out = a_reg - b_reg;
            6'h24:   alu_out = a_reg & b_reg;
            6'h25:   alu_out = a_reg | b_reg;
            6'h2A:   alu_out = {31'd0, $signed(a_reg) < $signed(b_reg)};
            default: alu_out = '0;
         endcase
      end
   end

   assign pc_seq    = pc_q + ADDR_W'(1);
   assign pc_branch = pc_q + ADDR_W'(1) + imm_reg[ADDR_W-1:0];
   assign data_addr = res_reg[ADDR_W-1:0];

   assign wb_dest = (opcode == OP_RTYPE) ? rd : rt;
   assign wb_data = (opcode == OP_LW) ? mdr : res_reg;
   // enable aborts the in-flight instruction, so it also suppresses the write
   assign rf_we   = (state == S_WB) && !enable && (wb_dest != 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         pc_q      <= '0;
         retired_q <= '0;
         ir        <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         imm_reg   <= '0;
         res_reg   <= '0;
         mdr       <= '0;
      end else if (enable) begin
         state <= S_IDLE;
         pc_q  <= '0;
      end else begin
         case (state)
            S_IDLE, S_HALT: begin
               if (start) state <= S_FETCH;
            end
            S_FETCH: begin
               ir    <= imem[pc_q];
               state <= S_DECODE;
            end
            S_DECODE: begin
               a_reg   <= rf[rs];
               b_reg   <= rf[rt];
               imm_reg <= {{16{ir[15]}}, ir[15:0]};
               state   <= S_EXEC;
            end
            S_EXEC: begin
               res_reg <= alu_out;
               if (opcode == HALT_OPC) begin
                  state <= S_HALT;
               end else if (opcode == OP_LW || opcode == OP_SW) begin
                  state <= S_MEM;
               end else if (rtype_ok || opcode == OP_ADDI) begin
                  state <= S_WB;
               end else begin
                  // beq, j and anything unsupported retire here
                  if (opcode == OP_BEQ && a_reg == b_reg) pc_q <= pc_branch;
                  else if (opcode == OP_J)                pc_q <= ir[ADDR_W-1:0];
                  else                                    pc_q <= pc_seq;
                  retired_q <= retired_q + 32'd1;
                  state     <= S_FETCH;
               end
            end
            S_MEM: begin
               if (opcode == OP_LW) begin
                  mdr   <= dmem[data_addr];
                  state <= S_WB;
               end else begin
                  pc_q      <= pc_seq;
                  retired_q <= retired_q + 32'd1;
                  state     <= S_FETCH;
               end
            end
            S_WB: begin
               pc_q      <= pc_seq;
               retired_q <= retired_q + 32'd1;
               state     <= S_FETCH;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (rf_we) begin
         rf[wb_dest] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && enable) imem[inst_write_address] <= inst_write_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (enable)
            dmem[mem_write_input_address] <= mem_write_input_data;
         else if (state == S_MEM && opcode == OP_SW)
            dmem[data_addr] <= b_reg;
      end
   end

   assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];
   assign busy     = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                     (state == S_MEM) || (state == S_WB);
   assign halted   = (state == S_HALT);
   assign pc       = pc_q;
   assign retired  = retired_q;

endmodule

// File: tb/tb_mc_mips_core.sv
// Testbench for mc_mips_core: an instruction-level reference model of the ISA
// (memories, registers, pc, retired) predicts the architectural state at every
// instruction boundary; directed programs cover load/run, memory round trip,
// branch/jump wrap, register-0 guard, abort and reset races, and random
// programs exercise the ALU and memory paths.

module tb_mc_mips_core;
   localparam int          AW     = 10;
   localparam int          DEPTH  = 1 << AW;
   localparam logic [31:0] HALT_W = 32'hFC000000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [AW-1:0] inst_write_address = '0;
   logic [31:0]   inst_write_data = '0;
   logic [AW-1:0] mem_write_input_address = '0;
   logic [31:0]   mem_write_input_data = '0;
   logic          start = 1'b0;
   logic [4:0]    dbg_addr = '0;
   logic [31:0]   dbg_data;
   logic          busy, halted;
   logic [AW-1:0] pc;
   logic [31:0]   retired;

   mc_mips_core #(.ADDR_W(AW), .HALT_OPC(6'h3F)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .inst_write_address(inst_write_address), .inst_write_data(inst_write_data),
      .mem_write_input_address(mem_write_input_address),
      .mem_write_input_data(mem_write_input_data),
      .start(start), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .busy(busy), .halted(halted), .pc(pc), .retired(retired)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] m_imem [DEPTH];
   logic [31:0] m_dmem [DEPTH];
   logic [31:0] m_rf   [32];
   int          m_pc;
   logic [31:0] m_ret;
   bit          m_halted;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_wr(input logic [4:0] r, input logic [31:0] v);
      if (r != 5'd0) m_rf[r] = v;
   endtask

   // Execute one instruction of the ISA and report how many cycles it takes.
   task automatic m_step(output int cyc);
      logic [31:0] ins, a, b, imm;
      logic [5:0]  opc, fn;
      logic [4:0]  rs, rt, rd;
      int          addr, nxt;
      ins  = m_imem[m_pc];
      opc  = ins[31:26];
      fn   = ins[5:0];
      rs   = ins[25:21];
      rt   = ins[20:16];
      rd   = ins[15:11];
      imm  = {{16{ins[15]}}, ins[15:0]};
      a    = m_rf[rs];
      b    = m_rf[rt];
      addr = int'((a + imm) & 32'h3FF);
      nxt  = (m_pc + 1) % DEPTH;
      cyc  = 3;
      if (opc == 6'h3F) begin
         m_halted = 1'b1;
         return;
      end
      case (opc)
         6'h00: begin
            cyc = 4;
            case (fn)
               6'h20:   m_wr(rd, a + b);
               6'h22:   m_wr(rd, a - b);
               6'h24:   m_wr(rd, a & b);
               6'h25:   m_wr(rd, a | b);
               6'h2A:   m_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
               default: cyc = 3;
            endcase
         end
         6'h08: begin cyc = 4; m_wr(rt, a + imm); end
         6'h23: begin cyc = 5; m_wr(rt, m_dmem[addr]); end
         6'h2B: begin cyc = 4; m_dmem[addr] = b; end
         6'h04: if (a == b) nxt = (m_pc + 1 + int'($signed(imm))) & (DEPTH - 1);
         6'h02: nxt = int'(ins[AW-1:0]);
         default: ;
      endcase
      m_pc  = nxt;
      m_ret = m_ret + 32'd1;
   endtask

   task automatic load_word(input int ia, input logic [31:0] id, input int da, input logic [31:0] dd);
      enable                  = 1'b1;
      inst_write_address      = AW'(ia);
      inst_write_data         = id;
      mem_write_input_address = AW'(da);
      mem_write_input_data    = dd;
      @(negedge clk);
      m_imem[ia] = id;
      m_dmem[da] = dd;
      m_pc       = 0;
      m_halted   = 1'b0;
   endtask

   task automatic load_i(input int ia, input logic [31:0] id);
      load_word(ia, id, ia, m_dmem[ia]);
   endtask

   task automatic end_load();
      enable = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      for (int r = 0; r < 32; r++) begin
         dbg_addr = 5'(r);
         #1;
         chk($sformatf("%s_r%0d", tag, r), dbg_data, m_rf[r]);
      end
   endtask

   // Pulse start, then compare the DUT with the model at each instruction end.
   task automatic run_checked(input int max_instr, input string tag);
      int c;
      int k;
      start = 1'b1;
      m_halted = 1'b0;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (k < max_instr && !m_halted) begin
         m_step(c);
         repeat (c) @(negedge clk);
         chk($sformatf("%s_i%0d_pc", tag, k), 32'(pc), 32'(m_pc));
         chk($sformatf("%s_i%0d_ret", tag, k), retired, m_ret);
         chk($sformatf("%s_i%0d_halted", tag, k), 32'(halted), 32'(m_halted));
         chk($sformatf("%s_i%0d_busy", tag, k), 32'(busy), 32'(!m_halted));
         k++;
      end
   endtask

   task automatic gen_prog(input int n);
      logic [31:0] w;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  fns [6];
      fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24;
      fns[3] = 6'h25; fns[4] = 6'h2A; fns[5] = 6'h00;
      for (int k = 0; k < n; k++) begin
         rs = 5'($urandom_range(0, 7));
         rt = 5'($urandom_range(0, 7));
         rd = 5'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            0, 7: w = {6'h08, rs, rt, 16'($urandom)};
            1, 2: w = {6'h00, rs, rt, rd, 5'd0, fns[$urandom_range(0, 5)]};
            3:    w = {6'h2B, rs, rt, 16'($urandom)};
            4:    w = {6'h23, rs, rt, 16'($urandom)};
            5:    w = {6'h04, rs, rt, 16'($urandom_range(0, 2))};
            default: w = {6'h01, 26'($urandom)};
         endcase
         load_i(k, w);
      end
      for (int k = n; k < n + 4; k++) load_i(k, HALT_W);
      end_load();
   endtask

   initial begin
      for (int r = 0; r < 32; r++) m_rf[r] = '0;
      m_pc = 0; m_ret = '0; m_halted = 1'b0;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_retired", retired, 32'd0);

      for (int i = 0; i < DEPTH; i++) load_word(i, HALT_W, i, $urandom);
      end_load();
      check_regs("rst");

      // load-and-run
      load_i(0, 32'h20010005); load_i(1, 32'h20020007);
      load_i(2, 32'h00221820); load_i(3, HALT_W);
      end_load();
      run_checked(10, "run1");
      dbg_addr = 5'd3; #1;
      chk("run1_reg3", dbg_data, 32'd12);
      chk("run1_halted", 32'(halted), 32'd1);
      chk("run1_pc", 32'(pc), 32'd3);
      chk("run1_retired", retired, 32'd3);

      // memory round trip: sw then lw
      load_i(0, 32'hAC030004); load_i(1, 32'h8C040004); load_i(2, HALT_W);
      end_load();
      run_checked(5, "mem");
      dbg_addr = 5'd4; #1;
      chk("mem_reg4", dbg_data, 32'd12);
      check_regs("mem");

      // register-0 guard
      load_i(0, 32'h20000009); load_i(1, HALT_W);
      end_load();
      run_checked(3, "r0");
      dbg_addr = 5'd0; #1;
      chk("r0_dbg", dbg_data, 32'd0);
      chk("r0_retired", retired, 32'd6);

      // beq to itself at pc=5
      load_i(0, 32'h20010005);
      for (int i = 1; i < 5; i++) load_i(i, 32'h00000000);
      load_i(5, 32'h1021FFFF);
      end_load();
      run_checked(9, "beq");
      chk("beq_pc5", 32'(pc), 32'd5);
      load_word(1023, HALT_W, 100, m_dmem[100]);

      // jump to 1023, sequential wrap back to 0
      load_i(0, 32'h0BFFFFFF); load_i(1023, 32'h20050001);
      end_load();
      run_checked(3, "jmp");
      chk("jmp_pc", 32'(pc), 32'd1023);
      load_word(1, HALT_W, 100, m_dmem[100]);
      end_load();
      check_regs("jmp");

      // abort an sw in MEM
      load_word(0, 32'hAC030008, 8, 32'hDEAD0000);
      end_load();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_mem", 32'(busy), 32'd1);
      load_word(1, HALT_W, 100, m_dmem[100]);
      end_load();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_halted", 32'(halted), 32'd0);
      chk("abort_pc", 32'(pc), 32'd0);
      chk("abort_retired", retired, m_ret);
      dbg_addr = 5'd3; #1;
      chk("abort_reg3", dbg_data, 32'd12);
      load_i(0, 32'h8C060008);
      end_load();
      run_checked(3, "abort_lw");
      dbg_addr = 5'd6; #1;
      chk("abort_dmem8", dbg_data, 32'hDEAD0000);

      // random programs
      for (int p = 0; p < 4; p++) begin
         gen_prog(10 + p);
         run_checked(20, $sformatf("rnd%0d", p));
         check_regs($sformatf("rnd%0d", p));
      end

      // enable beats start
      start = 1'b1;
      load_word(1020, HALT_W, 100, m_dmem[100]);
      start = 1'b0;
      end_load();
      chk("ens_busy", 32'(busy), 32'd0);
      chk("ens_halted", 32'(halted), 32'd0);
      @(negedge clk);
      chk("ens_busy2", 32'(busy), 32'd0);

      // reset beats start, mid-instruction
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      for (int r = 0; r < 32; r++) m_rf[r] = '0;
      m_pc = 0; m_ret = '0; m_halted = 1'b0;
      chk("race_busy", 32'(busy), 32'd0);
      chk("race_halted", 32'(halted), 32'd0);
      chk("race_retired", retired, 32'd0);
      chk("race_pc", 32'(pc), 32'd0);
      @(negedge clk);
      chk("race_busy2", 32'(busy), 32'd0);
      check_regs("race");

      // memories survive reset: rerun the last random program from clean registers
      run_checked(20, "post_rst");
      check_regs("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
